mem_port_arbiter: RTL and testbench

// - Shares the single-port synchronous SRAM in riscv32b_fpga between the instruction-fetch (IF) port
//   and the load/store (LS) port of the 4-stage pipeline.
// - One access granted per cycle; tracks each granted read and routes the next-cycle read data to its owner.
// - Fixed LS-over-IF priority, with an optional starvation guard for fetch.

---
 rtl/mem_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-port synchronous SRAM between the instruction-fetch (IF)
//   port and the load/store (LS) port. At most one access is granted per cycle.
//   LS has fixed priority over IF. Each granted read is remembered for one
//   cycle so the SRAM read data can be routed back to the port that issued it.
//
// Optional feature:
//   `define ARB_STARVE_GUARD_EN  builds a fetch starvation guard. After IF has
//   been refused MAX_WAIT cycles in a row, IF is granted once even while LS is
//   requesting. Without the macro, LS priority is strict and no counter exists.
//
// Ports:
//   clk, rstn                   clock, asynchronous active-low reset
//   if_req/if_addr              fetch request and address
//   if_gnt                      fetch accepted this cycle (combinational)
//   if_rvalid/if_rdata          fetch data, one cycle after if_gnt
//   ls_req/ls_we/ls_be          load/store request, write flag, byte enables
//   ls_addr/ls_wdata            load/store address and store data
//   ls_gnt                      load/store accepted this cycle (combinational)
//   ls_rvalid/ls_rdata          load data, one cycle after a load grant
//   mem_en/mem_we/mem_be        SRAM enable, write enable, byte enables
//   mem_addr/mem_wdata          SRAM address and write data
//   mem_rdata                   SRAM read data (one cycle after a read)
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rstn,
    // fetch port
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    // load/store port
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [DW/8-1:0] ls_be,
    input  logic [AW-1:0]   ls_addr,
    input  logic [DW-1:0]   ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [DW-1:0]   ls_rdata,
    // SRAM port
    output logic            mem_en,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_be,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int unsigned BW = DW / 8;

    // Owner of the read issued in the previous cycle
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_IF_RD = 2'd1;
    localparam logic [1:0] ST_LS_RD = 2'd2;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic       w_force_if;
    logic       w_ls_win;
    logic       w_if_win;
    logic [1:0] r_state;
    logic [1:0] w_state_d;

    // ------------------------------------------------------------------------
    // Fetch starvation guard
    // ------------------------------------------------------------------------
`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] r_wait_cnt;

    // Counts consecutive refused fetch cycles; saturates instead of wrapping.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wait_cnt <= 4'd0;
        end else if (!if_req || if_gnt) begin
            r_wait_cnt <= 4'd0;
        end else if (r_wait_cnt != 4'hF) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    assign w_force_if = (r_wait_cnt == WAIT_LIMIT);
`else
    logic w_unused_wait_limit;

    assign w_unused_wait_limit = ^WAIT_LIMIT;
    assign w_force_if          = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Grant decision; both grants are forced low while in reset
    // ------------------------------------------------------------------------
    assign w_ls_win = ls_req & ~w_force_if;
    assign w_if_win = if_req & (~ls_req | w_force_if);

    assign ls_gnt = rstn & w_ls_win;
    assign if_gnt = rstn & w_if_win;

    // ------------------------------------------------------------------------
    // SRAM request mux; idle cycles drive all-zero
    // ------------------------------------------------------------------------
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            mem_en   = 1'b1;
            mem_be   = {BW{1'b1}};
            mem_addr = if_addr;
        end else if (ls_gnt) begin
            mem_en    = 1'b1;
            mem_we    = ls_we;
            mem_be    = ls_be;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Read ownership tracking; stores leave no pending response
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_d = ST_IDLE;
        if (if_gnt) begin
            w_state_d = ST_IF_RD;
        end else if (ls_gnt && !ls_we) begin
            w_state_d = ST_LS_RD;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    // ------------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------------
    assign if_rvalid = (r_state == ST_IF_RD);
    assign ls_rvalid = (r_state == ST_LS_RD);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    localparam int unsigned BW       = DW / 8;
    localparam int unsigned MAX_WAIT = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk;
    logic          rstn;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          ls_req;
    logic          ls_we;
    logic [BW-1:0] ls_be;
    logic [AW-1:0] ls_addr;
    logic [DW-1:0] ls_wdata;
    logic          ls_gnt;
    logic          ls_rvalid;
    logic [DW-1:0] ls_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [BW-1:0] mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_cmp;
    int n_err;

    mem_port_arbiter #(
        .AW       (AW),
        .DW       (DW),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_be     (ls_be),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h0000_0013;
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Environment SRAM: 256 words, indexed by addr[9:2]
    logic [31:0] sram [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr[9:2]];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: transaction-level view of who wins, what the SRAM sees,
    // and which port owns the word coming back next cycle.
    // ------------------------------------------------------------------------
    logic [31:0] shadow [256];
    int          m_owner;   // 0 none, 1 fetch, 2 load
    logic [31:0] m_raddr;
    int          m_wait;

    initial begin
        bit            force_if, e_if, e_ls, e_en, e_we;
        logic [3:0]    e_be;
        logic [31:0]   e_addr, e_wdata, e_ifd, e_lsd;
        m_owner = 0;
        m_wait  = 0;
        m_raddr = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                chk("rst_if_gnt", if_gnt, 0);
                chk("rst_ls_gnt", ls_gnt, 0);
                chk("rst_mem_en", mem_en, 0);
                chk("rst_mem_addr", mem_addr, 0);
                chk("rst_if_rvalid", if_rvalid, 0);
                chk("rst_ls_rvalid", ls_rvalid, 0);
                chk("rst_if_rdata", if_rdata, 0);
                chk("rst_ls_rdata", ls_rdata, 0);
                m_owner = 0;
                m_wait  = 0;
            end else begin
                force_if = GUARD && (m_wait == int'(MAX_WAIT));
                e_ls     = ls_req && !force_if;
                e_if     = if_req && !e_ls;
                e_en = 0; e_we = 0; e_be = 0; e_addr = 0; e_wdata = 0;
                if (e_if) begin
                    e_en = 1; e_be = 4'hF; e_addr = if_addr;
                end else if (e_ls) begin
                    e_en = 1; e_we = ls_we; e_be = ls_be; e_addr = ls_addr; e_wdata = ls_wdata;
                end
                e_ifd = (m_owner == 1) ? shadow[m_raddr[9:2]] : 32'h0;
                e_lsd = (m_owner == 2) ? shadow[m_raddr[9:2]] : 32'h0;
                chk("if_gnt", if_gnt, e_if);
                chk("ls_gnt", ls_gnt, e_ls);
                chk("mem_en", mem_en, e_en);
                chk("mem_we", mem_we, e_we);
                chk("mem_be", mem_be, e_be);
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wdata", mem_wdata, e_wdata);
                chk("if_rvalid", if_rvalid, m_owner == 1);
                chk("ls_rvalid", ls_rvalid, m_owner == 2);
                chk("if_rdata", if_rdata, e_ifd);
                chk("ls_rdata", ls_rdata, e_lsd);
                // advance to what the next cycle must look like
                if (e_ls && ls_we)
                    for (int b = 0; b < 4; b++)
                        if (ls_be[b]) shadow[ls_addr[9:2]][8*b +: 8] = ls_wdata[8*b +: 8];
                if (e_if) begin
                    m_owner = 1; m_raddr = if_addr;
                end else if (e_ls && !ls_we) begin
                    m_owner = 2; m_raddr = ls_addr;
                end else begin
                    m_owner = 0;
                end
                if (if_req && !e_if) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
                else m_wait = 0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus with hand-computed expectations
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_if, n_ls, first_if;
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) begin
            sram[i]   = init_word(i);
            shadow[i] = init_word(i);
        end
        mem_rdata = '0;
        rstn = 1'b0;
        if_req = 0; if_addr = '0;
        ls_req = 0; ls_we = 0; ls_be = '0; ls_addr = '0; ls_wdata = '0;

        repeat (2) @(negedge clk);
        chk("lit_reset_mem_en", mem_en, 0);
        chk("lit_reset_if_rvalid", if_rvalid, 0);
        step();
        rstn = 1'b1;

        // solo fetch
        step(); if_req = 1; if_addr = 32'h10;
        @(negedge clk);
        chk("lit_fetch_gnt", if_gnt, 1);
        chk("lit_fetch_mem_addr", mem_addr, 32'h10);
        step(); if_req = 0;
        @(negedge clk);
        chk("lit_fetch_rvalid", if_rvalid, 1);
        chk("lit_fetch_rdata", if_rdata, 32'h13);

        // collision: load wins, fetch follows once load drops
        step(); if_req = 1; if_addr = 32'h20; ls_req = 1; ls_we = 0; ls_addr = 32'h2000;
        @(negedge clk);
        chk("lit_coll_ls_gnt", ls_gnt, 1);
        chk("lit_coll_if_gnt", if_gnt, 0);
        step(); ls_req = 0;
        @(negedge clk);
        chk("lit_coll_ls_rvalid", ls_rvalid, 1);
        chk("lit_coll_ls_rdata", ls_rdata, 32'hC0DE_0000);
        chk("lit_coll_if_gnt2", if_gnt, 1);
        step(); if_req = 0;
        @(negedge clk);
        chk("lit_coll_if_rdata", if_rdata, 32'hC0DE_0008);

        // partial store then load back
        step(); ls_req = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 32'h40; ls_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("lit_st_mem_we", mem_we, 1);
        chk("lit_st_mem_be", mem_be, 4'b0011);
        step(); ls_we = 0; ls_be = 4'hF;
        @(negedge clk);
        chk("lit_st_no_rvalid", ls_rvalid, 0);
        step(); ls_req = 0;
        @(negedge clk);
        chk("lit_ld_rdata", ls_rdata, 32'hC0DE_BEEF);

        // back-to-back fetches
        step(); if_req = 1; if_addr = 32'h0;
        @(negedge clk);
        chk("lit_b2b_gnt0", if_gnt, 1);
        step(); if_addr = 32'h4;
        @(negedge clk);
        chk("lit_b2b_d0", if_rdata, 32'hC0DE_0000);
        step(); if_addr = 32'h8;
        @(negedge clk);
        chk("lit_b2b_d1", if_rdata, 32'hC0DE_0001);
        step(); if_req = 0;
        @(negedge clk);
        chk("lit_b2b_d2", if_rdata, 32'hC0DE_0002);
        chk("lit_b2b_rvalid2", if_rvalid, 1);
        step();
        @(negedge clk);
        chk("lit_b2b_done", if_rvalid, 0);

        // contention for 20 cycles
        step(); ls_req = 1; ls_we = 0; ls_addr = 32'h80; if_req = 1; if_addr = 32'h84;
        n_if = 0; n_ls = 0; first_if = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (if_gnt) begin
                n_if++;
                if (first_if == 0) first_if = c;
            end
            if (ls_gnt) n_ls++;
            if (c < 20) step();
        end
        if (GUARD) begin
            chk("lit_guard_first_if", first_if, 5);
            chk("lit_guard_n_if", n_if, 4);
            chk("lit_guard_n_ls", n_ls, 16);
        end else begin
            chk("lit_starve_n_if", n_if, 0);
            chk("lit_starve_n_ls", n_ls, 20);
        end
        step(); ls_req = 0; if_req = 0;
        step();

        // withdrawn fetch: refused one cycle, then dropped
        step(); ls_req = 1; ls_addr = 32'h88; if_req = 1; if_addr = 32'h8C;
        step(); ls_req = 0; if_req = 0;
        @(negedge clk);
        chk("lit_wd_if_gnt", if_gnt, 0);
        chk("lit_wd_ls_rvalid", ls_rvalid, 1);
        step();
        @(negedge clk);
        chk("lit_wd_if_rvalid", if_rvalid, 0);

        // reset in the cycle after a load grant
        step(); ls_req = 1; ls_we = 0; ls_addr = 32'h44;
        @(negedge clk);
        chk("lit_rr_gnt", ls_gnt, 1);
        step(); ls_req = 0; rstn = 0;
        @(negedge clk);
        chk("lit_rr_rvalid", ls_rvalid, 0);
        chk("lit_rr_rdata", ls_rdata, 0);
        step(); rstn = 1;
        @(negedge clk);
        chk("lit_rr_post_en", mem_en, 0);
        chk("lit_rr_post_rvalid", ls_rvalid, 0);
        step();
        @(negedge clk);
        chk("lit_rr_post_rvalid2", ls_rvalid, 0);

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
